// File: rtl/recv_ctrl.sv
// recv_ctrl: parses UART RX byte strobes into 5-byte command frames
// (HEADER, CMD, ARG_L, ARG_H, CHK). The frame is checked with an XOR checksum.
// Good frames pulse CmdValid. Data frames (CMD[7]=1) are also pushed into the
// downstream FIFO.
module recv_ctrl #(
  parameter logic [7:0] HEADER  = 8'hAA,
  parameter int         TIMEOUT = 50000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RxValid,
  input  logic [7:0]  RxData,
  input  logic        RxErr,
  input  logic        WrFull,
  output logic        WrReq,
  output logic [15:0] WrData,
  output logic        CmdValid,
  output logic [7:0]  Cmd,
  output logic [15:0] CmdArg,
  output logic        Busy,
  output logic [7:0]  ErrCnt,
  output logic        Ovf
);

  // The counter never needs to exceed TIMEOUT-1: the frame aborts on that value.
  localparam int             TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    GOT_HDR,
    GOT_CMD,
    GOT_ARGL,
    GOT_ARGH
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    rx_cmd_q, rx_cmd_d;
  logic [7:0]    rx_arg_l_q, rx_arg_l_d;
  logic [7:0]    rx_arg_h_q, rx_arg_h_d;
  logic          wr_req_q, wr_req_d;
  logic [15:0]   wr_data_q, wr_data_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [15:0]   cmd_arg_q, cmd_arg_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          ovf_q, ovf_d;
  logic          err_inc;
  logic          tmo_expired;

  // Frame parser: next state, latched bytes, output pulses and error events
  always_comb begin
    state_d     = state_q;
    rx_cmd_d    = rx_cmd_q;
    rx_arg_l_d  = rx_arg_l_q;
    rx_arg_h_d  = rx_arg_h_q;
    wr_req_d    = 1'b0;
    wr_data_d   = wr_data_q;
    cmd_valid_d = 1'b0;
    cmd_d       = cmd_q;
    cmd_arg_d   = cmd_arg_q;
    ovf_d       = ovf_q;
    err_inc     = 1'b0;
    // A byte arriving on the expiry cycle takes priority over the abort.
    tmo_expired = (state_q != IDLE) && (tmo_q == TMO_LAST) && !RxValid;

    if (RxErr) begin
      // The byte is discarded. In IDLE the state is already IDLE.
      err_inc = 1'b1;
      state_d = IDLE;
    end else if (RxValid) begin
      case (state_q)
        IDLE: begin
          if (RxData == HEADER) state_d = GOT_HDR;
        end
        GOT_HDR: begin
          rx_cmd_d = RxData;
          state_d  = GOT_CMD;
        end
        GOT_CMD: begin
          rx_arg_l_d = RxData;
          state_d    = GOT_ARGL;
        end
        GOT_ARGL: begin
          rx_arg_h_d = RxData;
          state_d    = GOT_ARGH;
        end
        GOT_ARGH: begin
          state_d = IDLE;
          if (RxData == (rx_cmd_q ^ rx_arg_l_q ^ rx_arg_h_q)) begin
            cmd_valid_d = 1'b1;
            cmd_d       = rx_cmd_q;
            cmd_arg_d   = {rx_arg_h_q, rx_arg_l_q};
            if (rx_cmd_q[7]) begin
              if (WrFull) begin
                ovf_d   = 1'b1;
                err_inc = 1'b1;
              end else begin
                wr_req_d  = 1'b1;
                wr_data_d = {rx_arg_h_q, rx_arg_l_q};
              end
            end
          end else begin
            err_inc = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (tmo_expired) begin
      err_inc = 1'b1;
      state_d = IDLE;
    end

    // Inter-byte counter: restarts on every strobe, parked at zero outside a frame
    if (state_d == IDLE || RxValid) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    // Several simultaneous causes still count as one error; saturate at FF
    if (err_inc && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State and output registers, cleared asynchronously by RST
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      rx_cmd_q    <= 8'h00;
      rx_arg_l_q  <= 8'h00;
      rx_arg_h_q  <= 8'h00;
      wr_req_q    <= 1'b0;
      wr_data_q   <= 16'h0000;
      cmd_valid_q <= 1'b0;
      cmd_q       <= 8'h00;
      cmd_arg_q   <= 16'h0000;
      err_cnt_q   <= 8'h00;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      rx_cmd_q    <= rx_cmd_d;
      rx_arg_l_q  <= rx_arg_l_d;
      rx_arg_h_q  <= rx_arg_h_d;
      wr_req_q    <= wr_req_d;
      wr_data_q   <= wr_data_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      cmd_arg_q   <= cmd_arg_d;
      err_cnt_q   <= err_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  assign WrReq    = wr_req_q;
  assign WrData   = wr_data_q;
  assign CmdValid = cmd_valid_q;
  assign Cmd      = cmd_q;
  assign CmdArg   = cmd_arg_q;
  assign ErrCnt   = err_cnt_q;
  assign Ovf      = ovf_q;
  assign Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_recv_ctrl.sv
// Bench for recv_ctrl. The first part is a directed vector table. Hand
// sequences then cover the multi-cycle corners. The last part is random
// traffic checked against a frame-level reference model.
module tb_recv_ctrl;

  localparam logic [7:0] HDR = 8'hAA;
  localparam int         TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_err = 1'b0;
  logic        wr_full = 1'b0;
  logic        wr_req;
  logic [15:0] wr_data;
  logic        cmd_valid;
  logic [7:0]  cmd;
  logic [15:0] cmd_arg;
  logic        busy;
  logic [7:0]  err_cnt;
  logic        ovf;

  int tests = 0;
  int fails = 0;

  recv_ctrl #(.HEADER(HDR), .TIMEOUT(TMO)) dut (
    .CLK(clk), .RST(rst_n), .RxValid(rx_valid), .RxData(rx_data), .RxErr(rx_err),
    .WrFull(wr_full), .WrReq(wr_req), .WrData(wr_data), .CmdValid(cmd_valid),
    .Cmd(cmd), .CmdArg(cmd_arg), .Busy(busy), .ErrCnt(err_cnt), .Ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        e;
    logic        full;
    logic        cv;
    logic        wr;
    logic [15:0] wd;
    logic [7:0]  cmd;
    logic [15:0] arg;
    logic [7:0]  err;
    logic        ovf;
    logic        busy;
  } vec_t;

  vec_t tbl[$];

  // The reference model works on whole frames: it collects the bytes of the
  // current frame in a queue and counts the idle cycles since the last strobe.
  logic [7:0]  mq[$];
  int          m_gap;
  logic        m_cv, m_wr, m_ovf;
  logic [15:0] m_wd, m_arg;
  logic [7:0]  m_cmd;
  int          m_err;

  function automatic vec_t V(input logic v, input logic [7:0] d, input logic e, input logic full,
                             input logic cv, input logic wr, input logic [15:0] wd,
                             input logic [7:0] c, input logic [15:0] arg, input logic [7:0] err,
                             input logic o, input logic b);
    vec_t r;
    r.v = v; r.d = d; r.e = e; r.full = full; r.cv = cv; r.wr = wr; r.wd = wd;
    r.cmd = c; r.arg = arg; r.err = err; r.ovf = o; r.busy = b;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_gap = 0; m_cv = 0; m_wr = 0; m_ovf = 0; m_wd = 0; m_arg = 0; m_cmd = 0; m_err = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic e, input logic full);
    logic       err;
    logic [7:0] c, al, ah;
    err = 0; m_cv = 0; m_wr = 0;
    if (mq.size() == 0) begin
      if (e) err = 1;
      else if (v && d == HDR) begin mq.push_back(d); m_gap = 0; end
    end else if (e) begin
      err = 1; mq.delete();
    end else if (v) begin
      mq.push_back(d); m_gap = 0;
      if (mq.size() == 5) begin
        c = mq[1]; al = mq[2]; ah = mq[3];
        if ((c ^ al ^ ah) == mq[4]) begin
          m_cv = 1; m_cmd = c; m_arg = {ah, al};
          if (c[7]) begin
            if (full) begin m_ovf = 1; err = 1; end
            else begin m_wr = 1; m_wd = {ah, al}; end
          end
        end else begin
          err = 1;
        end
        mq.delete();
      end
    end else begin
      m_gap++;
      if (m_gap == TMO) begin err = 1; mq.delete(); end
    end
    if (err && m_err < 255) m_err++;
  endtask

  // One clock: apply inputs, let the edge pass, and sample 1 ns later.
  task automatic drive(input logic v, input logic [7:0] d, input logic e, input logic f);
    rx_valid = v; rx_data = d; rx_err = e; wr_full = f;
    @(posedge clk);
    #1;
    model_step(v, d, e, f);
  endtask

  task automatic send5(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input logic [7:0] b4, input logic f);
    drive(1, b0, 0, f); drive(1, b1, 0, f); drive(1, b2, 0, f);
    drive(1, b3, 0, f); drive(1, b4, 0, f);
  endtask

  task automatic do_reset();
    rx_valid = 0; rx_data = 0; rx_err = 0; wr_full = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wrreq"}, 16'(wr_req), 16'h0);
    chk({tag, "_wrdata"}, wr_data, 16'h0);
    chk({tag, "_cmdvalid"}, 16'(cmd_valid), 16'h0);
    chk({tag, "_cmd"}, 16'(cmd), 16'h0);
    chk({tag, "_cmdarg"}, cmd_arg, 16'h0);
    chk({tag, "_busy"}, 16'(busy), 16'h0);
    chk({tag, "_errcnt"}, 16'(err_cnt), 16'h0);
    chk({tag, "_ovf"}, 16'(ovf), 16'h0);
  endtask

  // Builds one random transaction worth of bytes for the random phase.
  task automatic push_frame(inout logic [7:0] sq[$]);
    int         kind;
    logic [7:0] c, al, ah;
    kind = $urandom_range(0, 9);
    c  = 8'($urandom);
    al = ($urandom_range(0, 7) == 0) ? HDR : 8'($urandom);
    ah = 8'($urandom);
    if (kind <= 5) begin
      sq.push_back(HDR); sq.push_back(c); sq.push_back(al); sq.push_back(ah);
      sq.push_back(c ^ al ^ ah);
    end else if (kind == 6) begin
      sq.push_back(HDR); sq.push_back(c); sq.push_back(al); sq.push_back(ah);
      sq.push_back(c ^ al ^ ah ^ 8'h01);
    end else if (kind == 7) begin
      sq.push_back(8'($urandom));
    end else begin
      sq.push_back(HDR); sq.push_back(c);
      if (kind == 9) sq.push_back(al);
    end
  endtask

  initial begin
    logic [7:0] sq[$];
    int         gap;
    logic       v, e, f;
    logic [7:0] d;

    // Reset state, sampled while reset is still asserted.
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    do_reset();

    // Directed vectors: v, d, e, full | cv, wr, wd, cmd, arg, err, ovf, busy
    // Good command frame
    tbl.push_back(V(1, 8'hAA, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0000, 8'd0, 0, 1));
    tbl.push_back(V(1, 8'h05, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0000, 8'd0, 0, 1));
    tbl.push_back(V(1, 8'h34, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0000, 8'd0, 0, 1));
    tbl.push_back(V(1, 8'h12, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0000, 8'd0, 0, 1));
    tbl.push_back(V(1, 8'h23, 0, 0, 1, 0, 16'h0000, 8'h05, 16'h1234, 8'd0, 0, 0));
    tbl.push_back(V(0, 8'h00, 0, 0, 0, 0, 16'h0000, 8'h05, 16'h1234, 8'd0, 0, 0));
    // Data frame with the FIFO free
    tbl.push_back(V(1, 8'hAA, 0, 0, 0, 0, 16'h0000, 8'h05, 16'h1234, 8'd0, 0, 1));
    tbl.push_back(V(1, 8'h81, 0, 0, 0, 0, 16'h0000, 8'h05, 16'h1234, 8'd0, 0, 1));
    tbl.push_back(V(1, 8'hCD, 0, 0, 0, 0, 16'h0000, 8'h05, 16'h1234, 8'd0, 0, 1));
    tbl.push_back(V(1, 8'hAB, 0, 0, 0, 0, 16'h0000, 8'h05, 16'h1234, 8'd0, 0, 1));
    tbl.push_back(V(1, 8'hE7, 0, 0, 1, 1, 16'hABCD, 8'h81, 16'hABCD, 8'd0, 0, 0));
    // Back-to-back data frame
    tbl.push_back(V(1, 8'hAA, 0, 0, 0, 0, 16'hABCD, 8'h81, 16'hABCD, 8'd0, 0, 1));
    tbl.push_back(V(1, 8'h82, 0, 0, 0, 0, 16'hABCD, 8'h81, 16'hABCD, 8'd0, 0, 1));
    tbl.push_back(V(1, 8'h11, 0, 0, 0, 0, 16'hABCD, 8'h81, 16'hABCD, 8'd0, 0, 1));
    tbl.push_back(V(1, 8'h22, 0, 0, 0, 0, 16'hABCD, 8'h81, 16'hABCD, 8'd0, 0, 1));
    tbl.push_back(V(1, 8'hB1, 0, 0, 1, 1, 16'h2211, 8'h82, 16'h2211, 8'd0, 0, 0));
    // Junk in IDLE
    tbl.push_back(V(1, 8'h00, 0, 0, 0, 0, 16'h2211, 8'h82, 16'h2211, 8'd0, 0, 0));
    tbl.push_back(V(1, 8'hFF, 0, 0, 0, 0, 16'h2211, 8'h82, 16'h2211, 8'd0, 0, 0));
    tbl.push_back(V(1, 8'h55, 0, 0, 0, 0, 16'h2211, 8'h82, 16'h2211, 8'd0, 0, 0));
    // Bad checksum
    tbl.push_back(V(1, 8'hAA, 0, 0, 0, 0, 16'h2211, 8'h82, 16'h2211, 8'd0, 0, 1));
    tbl.push_back(V(1, 8'h05, 0, 0, 0, 0, 16'h2211, 8'h82, 16'h2211, 8'd0, 0, 1));
    tbl.push_back(V(1, 8'h34, 0, 0, 0, 0, 16'h2211, 8'h82, 16'h2211, 8'd0, 0, 1));
    tbl.push_back(V(1, 8'h12, 0, 0, 0, 0, 16'h2211, 8'h82, 16'h2211, 8'd0, 0, 1));
    tbl.push_back(V(1, 8'h00, 0, 0, 0, 0, 16'h2211, 8'h82, 16'h2211, 8'd1, 0, 0));
    // Data frame dropped on WrFull
    tbl.push_back(V(1, 8'hAA, 0, 1, 0, 0, 16'h2211, 8'h82, 16'h2211, 8'd1, 0, 1));
    tbl.push_back(V(1, 8'h81, 0, 1, 0, 0, 16'h2211, 8'h82, 16'h2211, 8'd1, 0, 1));
    tbl.push_back(V(1, 8'hCD, 0, 1, 0, 0, 16'h2211, 8'h82, 16'h2211, 8'd1, 0, 1));
    tbl.push_back(V(1, 8'hAB, 0, 1, 0, 0, 16'h2211, 8'h82, 16'h2211, 8'd1, 0, 1));
    tbl.push_back(V(1, 8'hE7, 0, 1, 1, 0, 16'h2211, 8'h81, 16'hABCD, 8'd2, 1, 0));
    // Command frame with WrFull high: unaffected by the full flag
    tbl.push_back(V(1, 8'hAA, 0, 1, 0, 0, 16'h2211, 8'h81, 16'hABCD, 8'd2, 1, 1));
    tbl.push_back(V(1, 8'h05, 0, 1, 0, 0, 16'h2211, 8'h81, 16'hABCD, 8'd2, 1, 1));
    tbl.push_back(V(1, 8'h34, 0, 1, 0, 0, 16'h2211, 8'h81, 16'hABCD, 8'd2, 1, 1));
    tbl.push_back(V(1, 8'h12, 0, 1, 0, 0, 16'h2211, 8'h81, 16'hABCD, 8'd2, 1, 1));
    tbl.push_back(V(1, 8'h23, 0, 1, 1, 0, 16'h2211, 8'h05, 16'h1234, 8'd2, 1, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].e, tbl[i].full);
      $display("[TB] vec %0d v=%0b d=%h e=%0b full=%0b -> cv=%0b wr=%0b wd=%h cmd=%h arg=%h err=%0d ovf=%0b busy=%0b",
               i, tbl[i].v, tbl[i].d, tbl[i].e, tbl[i].full, cmd_valid, wr_req, wr_data,
               cmd, cmd_arg, err_cnt, ovf, busy);
      chk("vec_cmdvalid", 16'(cmd_valid), 16'(tbl[i].cv));
      chk("vec_wrreq", 16'(wr_req), 16'(tbl[i].wr));
      chk("vec_wrdata", wr_data, tbl[i].wd);
      chk("vec_cmd", 16'(cmd), 16'(tbl[i].cmd));
      chk("vec_cmdarg", cmd_arg, tbl[i].arg);
      chk("vec_errcnt", 16'(err_cnt), 16'(tbl[i].err));
      chk("vec_ovf", 16'(ovf), 16'(tbl[i].ovf));
      chk("vec_busy", 16'(busy), 16'(tbl[i].busy));
    end

    // Timeout: Busy holds for 7 idle cycles and drops on the 8th.
    do_reset();
    drive(1, 8'hAA, 0, 0); drive(1, 8'h05, 0, 0);
    repeat (7) drive(0, 8'h00, 0, 0);
    $display("[TB] timeout: 7 idle cycles after last strobe busy=%0b err=%0d", busy, err_cnt);
    chk("tmo_busy_before", 16'(busy), 16'h1);
    chk("tmo_err_before", 16'(err_cnt), 16'h0);
    drive(0, 8'h00, 0, 0);
    $display("[TB] timeout: 8 idle cycles after last strobe busy=%0b err=%0d", busy, err_cnt);
    chk("tmo_busy_after", 16'(busy), 16'h0);
    chk("tmo_err_after", 16'(err_cnt), 16'h1);
    send5(8'hAA, 8'h05, 8'h34, 8'h12, 8'h23, 0);
    $display("[TB] after timeout frame cv=%0b cmd=%h arg=%h", cmd_valid, cmd, cmd_arg);
    chk("tmo_next_cv", 16'(cmd_valid), 16'h1);
    chk("tmo_next_arg", cmd_arg, 16'h1234);
    chk("tmo_next_err", 16'(err_cnt), 16'h1);

    // A strobe on the expiry cycle is accepted.
    drive(1, 8'hAA, 0, 0); drive(1, 8'h0A, 0, 0);
    repeat (7) drive(0, 8'h00, 0, 0);
    drive(1, 8'h34, 0, 0);
    $display("[TB] expiry strobe busy=%0b err=%0d", busy, err_cnt);
    chk("exp_busy", 16'(busy), 16'h1);
    chk("exp_err", 16'(err_cnt), 16'h1);
    drive(1, 8'h12, 0, 0); drive(1, 8'h0A ^ 8'h34 ^ 8'h12, 0, 0);
    $display("[TB] expiry frame cv=%0b cmd=%h arg=%h", cmd_valid, cmd, cmd_arg);
    chk("exp_cv", 16'(cmd_valid), 16'h1);
    chk("exp_cmd", 16'(cmd), 16'h0A);
    chk("exp_arg", cmd_arg, 16'h1234);

    // RxErr together with RxValid mid-frame aborts; later bytes are ignored in IDLE.
    do_reset();
    drive(1, 8'hAA, 0, 0); drive(1, 8'h05, 0, 0);
    drive(1, 8'h34, 1, 0);
    $display("[TB] rxerr mid-frame busy=%0b err=%0d", busy, err_cnt);
    chk("rxerr_busy", 16'(busy), 16'h0);
    chk("rxerr_err", 16'(err_cnt), 16'h1);
    drive(1, 8'h12, 0, 0); drive(1, 8'h23, 0, 0);
    chk("rxerr_no_cv", 16'(cmd_valid), 16'h0);
    drive(0, 8'h00, 1, 0);
    $display("[TB] rxerr in idle busy=%0b err=%0d", busy, err_cnt);
    chk("rxerr_idle_err", 16'(err_cnt), 16'h2);
    chk("rxerr_idle_busy", 16'(busy), 16'h0);

    // 300 bad frames saturate the error counter.
    do_reset();
    for (int i = 0; i < 300; i++) send5(8'hAA, 8'h05, 8'h34, 8'h12, 8'h00, 0);
    $display("[TB] 300 bad frames err=%0d", err_cnt);
    chk("sat_err", 16'(err_cnt), 16'h00FF);

    // Asynchronous reset in the middle of a frame, away from the clock edge.
    do_reset();
    send5(8'hAA, 8'h81, 8'hCD, 8'hAB, 8'hE7, 1);
    send5(8'hAA, 8'h81, 8'hCD, 8'hAB, 8'hE7, 0);
    drive(1, 8'hAA, 0, 0); drive(1, 8'h81, 0, 0);
    chk("arst_pre_busy", 16'(busy), 16'h1);
    chk("arst_pre_ovf", 16'(ovf), 16'h1);
    rx_valid = 0; rx_data = 0;
    #2;
    rst_n = 0;
    #1;
    $display("[TB] async reset mid-frame busy=%0b cmd=%h err=%0d ovf=%0b", busy, cmd, err_cnt, ovf);
    check_all_zero("arst");
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    model_reset();

    // Random traffic against the reference model.
    sq.delete();
    gap = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      v = 0; d = 8'($urandom);
      if (gap > 0) begin
        gap--;
      end else begin
        if (sq.size() == 0) push_frame(sq);
        v = 1; d = sq.pop_front();
        gap = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 10) : $urandom_range(0, 1);
      end
      e = ($urandom_range(0, 63) == 0);
      f = $urandom_range(0, 1);
      drive(v, d, e, f);
      if (m_cv || cmd_valid)
        $display("[TB] rnd cyc %0d cmd=%h arg=%h wr=%0b err=%0d", cyc, cmd, cmd_arg, wr_req, err_cnt);
      chk("rnd_cmdvalid", 16'(cmd_valid), 16'(m_cv));
      chk("rnd_wrreq", 16'(wr_req), 16'(m_wr));
      chk("rnd_wrdata", wr_data, m_wd);
      chk("rnd_cmd", 16'(cmd), 16'(m_cmd));
      chk("rnd_cmdarg", cmd_arg, m_arg);
      chk("rnd_errcnt", 16'(err_cnt), 16'(m_err));
      chk("rnd_ovf", 16'(ovf), 16'(m_ovf));
      chk("rnd_busy", 16'(busy), 16'(mq.size() != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/recv_ctrl.md
# recv_ctrl

UART receive-side controller: the counterpart to the FIFO-to-UART send path. It takes single-byte strobes from the UART RX core and parses them into fixed 5-byte command frames, checking each frame with an XOR checksum. Good frames are issued as a command/argument pulse to the ECT control logic. Data-class frames additionally have their 16-bit argument written into the downstream data FIFO.

## Interface
Parameters:
- HEADER, 8'hAA, frame start byte
- TIMEOUT, 50000, maximum CLK cycles allowed between bytes inside a frame (≥2)

Ports:
- CLK  in  1  system clock, all logic on posedge
- RST  in  1  reset, asynchronous, active-low
- RxValid  in  1  one-cycle strobe from UART RX; RxData valid in that cycle
- RxData  in  8  received byte
- RxErr  in  1  one-cycle framing/parity error strobe from UART RX
- WrFull  in  1  downstream FIFO full (high = full)
- WrReq  out  1  FIFO write request, one-cycle pulse
- WrData  out  16  FIFO write data, {ARG_H, ARG_L}
- CmdValid  out  1  one-cycle pulse per accepted frame
- Cmd  out  8  command byte of last accepted frame
- CmdArg  out  16  argument of last accepted frame, {ARG_H, ARG_L}
- Busy  out  1  high while a frame is partially received
- ErrCnt  out  8  saturating error counter
- Ovf  out  1  sticky, set when a data frame is dropped on WrFull

## Operation
- Frame format is HEADER, CMD, ARG_L, ARG_H, CHK. Low byte precedes high byte, the same order used on the TX side.
- CHK must equal CMD ^ ARG_L ^ ARG_H.
- State machine states: IDLE, GOT_HDR, GOT_CMD, GOT_ARGL, GOT_ARGH.
- IDLE → GOT_HDR on RxValid with RxData == HEADER. Any other byte in IDLE is ignored silently, with no error.
- GOT_HDR → GOT_CMD on RxValid; the byte is latched as cmd.
- GOT_CMD → GOT_ARGL on RxValid; the byte is latched as arg_l.
- GOT_ARGL → GOT_ARGH on RxValid; the byte is latched as arg_h.
- GOT_ARGH → IDLE on RxValid. The checksum is evaluated on that byte.
  - Match: Cmd/CmdArg are loaded and CmdValid pulses.
  - Mismatch: ErrCnt increments and no outputs change.
- Data frames (Cmd[7] == 1) that pass the checksum:
  - WrFull low: WrData = {arg_h, arg_l} and WrReq pulses in the same cycle as CmdValid.
  - WrFull high: no WrReq, Ovf is set, ErrCnt increments. CmdValid still pulses.
- Inside a frame, a byte equal to HEADER is treated as data; there is no mid-frame resync.
- Error/abort conditions force the state to IDLE and increment ErrCnt:
  - RxErr in any state other than IDLE.
  - Inter-byte timeout.
- RxErr in IDLE increments ErrCnt and leaves the state unchanged.
- Timeout counter:
  - Cleared on every RxValid.
  - Counts while state != IDLE and is held at 0 in IDLE.
  - When it reaches TIMEOUT-1 without an RxValid, that cycle aborts the frame.
- ErrCnt saturates at 8'hFF. When several error causes occur in one cycle, it increments by exactly 1.
- Busy = (state != IDLE), combinational from the state register.
- Reset values: WrReq=0, WrData=0, CmdValid=0, Cmd=0, CmdArg=0, Busy=0, ErrCnt=0, Ovf=0. State is IDLE and the timeout counter is 0.
- Reset mid-frame discards the partial frame immediately.

## Timing
- All outputs are registered except Busy.
- Latency: if the CHK strobe is sampled at edge T, CmdValid, WrReq, Cmd, CmdArg and WrData update at edge T and are visible in cycle T+1. The pulses last exactly one cycle.
- WrFull is sampled in the same cycle as the CHK strobe.
- Back-to-back frames need no idle gap. A HEADER strobe one cycle after CHK starts a new frame.
- RxValid and RxErr in the same cycle: RxErr wins, the byte is discarded, and the frame aborts.
- RxValid in the same cycle the counter reaches TIMEOUT-1: the byte wins, it is accepted and the counter clears.
- RxValid may arrive every cycle; every strobe is consumed, with no back-pressure to UART RX.
- Cmd/CmdArg hold their values until the next accepted frame.

## Test plan
- Good command frame: bytes AA 05 34 12 23 → one CmdValid pulse, Cmd=05, CmdArg=1234, WrReq stays 0, ErrCnt=0.
- Data frame with FIFO free: AA 81 CD AB E7, WrFull=0 → CmdValid and WrReq pulse together in the cycle after the CHK strobe, WrData=ABCD. A second back-to-back frame is also accepted.
- Bad checksum and FIFO overflow:
  - AA 05 34 12 00 → no CmdValid, ErrCnt=1.
  - AA 81 CD AB E7 with WrFull=1 → CmdValid=1, WrReq=0, Ovf=1, ErrCnt=2.
- Timeout (TIMEOUT=8): send AA 05, then stop → Busy drops 8 cycles after the last strobe, ErrCnt=1.
  - Next frame AA 05 34 12 23 is accepted normally.
  - A strobe landing exactly on the expiry cycle is accepted.
- Resilience:
  - Junk bytes 00 FF 55 in IDLE → no error.
  - RxErr asserted together with RxValid mid-frame → abort, ErrCnt=1.
  - 300 bad frames → ErrCnt=FF.
  - Assert RST mid-frame → all outputs return to 0 asynchronously.
